// File: rtl/branch_target_buffer_if.sv
// Fetch/EX-side bundle for the branch target buffer.
//   Lookup : pc -> btb_hit, btb_target, btb_is_jal (combinational)
//   Update : upd_en, upd_pc, upd_target, upd_taken, upd_jal (EX resolution)
//   Control: PL_stall blocks array writes, inv_all flushes every entry
// master = pipeline side driving requests, slave = the BTB itself.
interface branch_target_buffer_if;
  logic        PL_stall;
  logic        inv_all;
  logic [31:0] pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        btb_is_jal;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_jal;

  modport master (
    output PL_stall, inv_all, pc, upd_en, upd_pc, upd_target, upd_taken, upd_jal,
    input  btb_hit, btb_target, btb_is_jal
  );

  modport slave (
    input  PL_stall, inv_all, pc, upd_en, upd_pc, upd_target, upd_taken, upd_jal,
    output btb_hit, btb_target, btb_is_jal
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer for the IF stage.
// Zero-latency lookup of pc; trained from EX through the update port with
// per-entry saturating confidence counters steering allocation/eviction.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears valid/conf)
//   bus   - branch_target_buffer_if.slave (lookup, update, stall, inv_all)
module branch_target_buffer #(
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int CONF_WIDTH  = 2
) (
  input  logic clk,
  input  logic rst_n,
  branch_target_buffer_if.slave bus
);
  localparam int N = 1 << INDEX_WIDTH;
  localparam int TAG_LO = INDEX_WIDTH + 2;
  localparam int TAG_HI = INDEX_WIDTH + TAG_WIDTH + 1;
  localparam logic [CONF_WIDTH-1:0] CMAX = '1;
  localparam logic [CONF_WIDTH-1:0] CONE = CONF_WIDTH'(1);

  // valid/conf are flops so reset and inv_all clear them in one cycle
  logic [N-1:0]                 r_valid;
  logic [N-1:0][CONF_WIDTH-1:0] r_conf;
  // payload storage: sync write, async read, no reset needed
  logic [TAG_WIDTH-1:0]         r_tag    [N];
  logic [31:0]                  r_target [N];
  logic                         r_jal    [N];

  logic [N-1:0]                 w_valid_nxt;
  logic [N-1:0][CONF_WIDTH-1:0] w_conf_nxt;
  logic                         w_data_we;

  // ---------------- lookup ----------------
  logic [INDEX_WIDTH-1:0] w_lk_idx;
  logic [TAG_WIDTH-1:0]   w_lk_tag;
  logic                   w_lk_hit;

  assign w_lk_idx = bus.pc[TAG_LO-1:2];
  assign w_lk_tag = bus.pc[TAG_HI:TAG_LO];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign bus.btb_hit    = w_lk_hit;
  assign bus.btb_target = w_lk_hit ? r_target[w_lk_idx] : 32'h0;
  assign bus.btb_is_jal = w_lk_hit & r_jal[w_lk_idx];

  // ---------------- update ----------------
  logic [INDEX_WIDTH-1:0] w_up_idx;
  logic [TAG_WIDTH-1:0]   w_up_tag;
  logic                   w_up_go;
  logic                   w_up_v;
  logic [CONF_WIDTH-1:0]  w_up_c;
  logic                   w_up_hit;

  assign w_up_idx = bus.upd_pc[TAG_LO-1:2];
  assign w_up_tag = bus.upd_pc[TAG_HI:TAG_LO];
  assign w_up_go  = bus.upd_en & ~bus.PL_stall & ~bus.inv_all;
  assign w_up_v   = r_valid[w_up_idx];
  assign w_up_c   = r_conf[w_up_idx];
  assign w_up_hit = w_up_v && (r_tag[w_up_idx] == w_up_tag);

  // pc[1:0] and address bits above the tag are deliberately ignored
  logic w_unused;
  assign w_unused = &{1'b0, bus.pc[1:0], bus.pc[31:TAG_HI+1],
                      bus.upd_pc[1:0], bus.upd_pc[31:TAG_HI+1]};

  always_comb begin
    w_valid_nxt = r_valid;
    w_conf_nxt  = r_conf;
    w_data_we   = 1'b0;
    if (bus.inv_all) begin
      // flush wins over any update, stalled or not
      w_valid_nxt = '0;
      w_conf_nxt  = '0;
    end else if (w_up_go) begin
      if (w_up_hit) begin
        if (bus.upd_taken) begin
          w_data_we = 1'b1;
          if (w_up_c != CMAX) w_conf_nxt[w_up_idx] = w_up_c + CONE;
        end else if (w_up_c != '0) begin
          w_conf_nxt[w_up_idx] = w_up_c - CONE;
        end else begin
          w_valid_nxt[w_up_idx] = 1'b0;
        end
      end else if (bus.upd_taken) begin
        if (!w_up_v || w_up_c == '0) begin
          // allocate; jal targets are certain, so start them saturated
          w_data_we              = 1'b1;
          w_valid_nxt[w_up_idx] = 1'b1;
          w_conf_nxt[w_up_idx]  = bus.upd_jal ? CMAX : CONE;
        end else begin
          // incumbent loses confidence each time a conflicting branch is taken
          w_conf_nxt[w_up_idx] = w_up_c - CONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_conf  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_conf  <= w_conf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_data_we) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bus.upd_target;
      r_jal[w_up_idx]    <= bus.upd_jal;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_target_buffer_if bus();
  branch_target_buffer #(.INDEX_WIDTH(4), .TAG_WIDTH(8), .CONF_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  // 16 entries, index = (pc/4) mod 16, tag = (pc/64) mod 256, conf in 0..3
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned tgt;
    bit          jal;
    int          conf;
  } ent_t;
  ent_t m [16];

  function automatic int unsigned f_idx(input logic [31:0] a);
    return (a / 4) % 16;
  endfunction
  function automatic int unsigned f_tag(input logic [31:0] a);
    return (a / 64) % 256;
  endfunction

  initial for (int i = 0; i < 16; i++) m[i] = '{0, 0, 0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m[i].v = 0; m[i].conf = 0; end
    end else if (bus.inv_all) begin
      for (int i = 0; i < 16; i++) begin m[i].v = 0; m[i].conf = 0; end
    end else if (bus.upd_en && !bus.PL_stall) begin
      int unsigned ix;
      int unsigned tg;
      ix = f_idx(bus.upd_pc);
      tg = f_tag(bus.upd_pc);
      if (m[ix].v && m[ix].tag == tg) begin
        if (bus.upd_taken) begin
          m[ix].tgt  = bus.upd_target;
          m[ix].jal  = bus.upd_jal;
          m[ix].conf = (m[ix].conf >= 3) ? 3 : m[ix].conf + 1;
        end else if (m[ix].conf > 0) m[ix].conf--;
        else m[ix].v = 0;
      end else if (bus.upd_taken) begin
        if (!m[ix].v || m[ix].conf == 0)
          m[ix] = '{1, tg, bus.upd_target, bus.upd_jal, bus.upd_jal ? 3 : 1};
        else m[ix].conf--;
      end
    end
  end

  function automatic bit mod_hit(input logic [31:0] a);
    return m[f_idx(a)].v && m[f_idx(a)].tag == f_tag(a);
  endfunction

  // every-cycle compare of DUT against the model
  always @(negedge clk) begin
    bit          eh;
    logic [31:0] et;
    bit          ej;
    eh = mod_hit(bus.pc);
    et = eh ? m[f_idx(bus.pc)].tgt : 32'h0;
    ej = eh ? m[f_idx(bus.pc)].jal : 1'b0;
    n_cmp++;
    if (bus.btb_hit !== eh || bus.btb_target !== et || bus.btb_is_jal !== ej) begin
      n_fail++;
      $display("FAIL model pc=%h got hit=%b tgt=%h jal=%b want hit=%b tgt=%h jal=%b",
               bus.pc, bus.btb_hit, bus.btb_target, bus.btb_is_jal, eh, et, ej);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input string nm, input bit h, input logic [31:0] t, input bit j);
    n_cmp++;
    if (bus.btb_hit !== h || bus.btb_target !== t || bus.btb_is_jal !== j) begin
      n_fail++;
      $display("FAIL %s got hit=%b tgt=%h jal=%b want hit=%b tgt=%h jal=%b",
               nm, bus.btb_hit, bus.btb_target, bus.btb_is_jal, h, t, j);
    end
  endtask

  // one cycle: inputs are already set; literal check point is negedge+1
  task automatic step();
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.upd_en = 0; bus.PL_stall = 0; bus.inv_all = 0;
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input bit tk, input bit jl);
    bus.upd_en = 1; bus.upd_pc = p; bus.upd_target = t; bus.upd_taken = tk; bus.upd_jal = jl;
    step();
    bus.upd_en = 0;
  endtask

  task automatic look(input string nm, input logic [31:0] p, input bit h,
                      input logic [31:0] t, input bit j);
    bus.pc = p;
    @(negedge clk); #1;
    lit(nm, h, t, j);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.pc = 32'h40; bus.upd_pc = 0; bus.upd_target = 0; bus.upd_taken = 0; bus.upd_jal = 0;
    idle();
    #3 lit("reset_state", 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    look("first_after_rst", 32'h40, 0, 32'h0, 0);

    // allocate, then confidence 1 -> 0 -> invalid
    upd(32'h40, 32'h100, 1, 0);
    look("alloc_0x40", 32'h40, 1, 32'h100, 0);
    upd(32'h40, 32'h0, 0, 0);
    look("nt_conf0_hit", 32'h40, 1, 32'h100, 0);
    upd(32'h40, 32'h0, 0, 0);
    look("nt_invalid", 32'h40, 0, 32'h0, 0);

    // conf=2 incumbent aged out by alias 0x440
    upd(32'h40, 32'h100, 1, 0);
    upd(32'h40, 32'h100, 1, 0);
    upd(32'h440, 32'h300, 1, 0);
    look("alias1_keep", 32'h40, 1, 32'h100, 0);
    upd(32'h440, 32'h300, 1, 0);
    look("alias2_keep", 32'h40, 1, 32'h100, 0);
    upd(32'h440, 32'h300, 1, 0);
    look("alias3_alloc", 32'h440, 1, 32'h300, 0);
    look("alias3_evict", 32'h40, 0, 32'h0, 0);

    // flush, then jal entry at conf=3 survives three aliases
    bus.inv_all = 1; step(); bus.inv_all = 0;
    upd(32'h80, 32'h200, 1, 1);
    look("jal_alloc", 32'h80, 1, 32'h200, 1);
    for (int k = 0; k < 3; k++) begin
      upd(32'h480, 32'h500, 1, 0);
      look("jal_retained", 32'h80, 1, 32'h200, 1);
    end
    upd(32'h480, 32'h500, 1, 0);
    look("jal_evicted", 32'h80, 0, 32'h0, 0);
    look("alias_480", 32'h480, 1, 32'h500, 0);

    // stall blocks the write; unstalled write not visible same cycle
    bus.PL_stall = 1;
    upd(32'h44, 32'h600, 1, 0);
    bus.PL_stall = 0;
    look("stall_nochg", 32'h44, 0, 32'h0, 0);
    bus.pc = 32'h44;
    bus.upd_en = 1; bus.upd_pc = 32'h44; bus.upd_target = 32'h600; bus.upd_taken = 1; bus.upd_jal = 0;
    @(negedge clk); #1;
    lit("no_bypass", 0, 32'h0, 0);
    @(posedge clk); #1;
    bus.upd_en = 0;
    look("after_write", 32'h44, 1, 32'h600, 0);

    // populate, then inv_all with a concurrent update
    upd(32'h48, 32'h700, 1, 0);
    upd(32'h4c, 32'h704, 1, 1);
    upd(32'h50, 32'h708, 1, 0);
    look("pop_4c", 32'h4c, 1, 32'h704, 1);
    bus.inv_all = 1;
    upd(32'h54, 32'h70c, 1, 0);
    bus.inv_all = 0;
    look("inv_44", 32'h44, 0, 32'h0, 0);
    look("inv_48", 32'h48, 0, 32'h0, 0);
    look("inv_4c", 32'h4c, 0, 32'h0, 0);
    look("inv_50", 32'h50, 0, 32'h0, 0);
    look("inv_upd_drop", 32'h54, 0, 32'h0, 0);

    // asynchronous reset mid-cycle, with an update pending that must be dropped
    upd(32'h48, 32'h800, 1, 0);
    look("pre_rst_hit", 32'h48, 1, 32'h800, 0);
    #2 rst_n = 0;
    #1 lit("async_rst", 0, 32'h0, 0);
    bus.upd_en = 1; bus.upd_pc = 32'h58; bus.upd_target = 32'h900; bus.upd_taken = 1;
    @(posedge clk); #1;
    bus.upd_en = 0;
    rst_n = 1;
    look("post_rst_48", 32'h48, 0, 32'h0, 0);
    look("post_rst_58", 32'h58, 0, 32'h0, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
